// File: rtl/mem_access_unit_if.sv
// Word-wide data memory bus between the load/store unit (master) and data memory (slave).
// Request fields are registered in the master and held stable until bus_gnt.
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_gnt,
        input  bus_rvalid,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_gnt,
        output bus_rvalid,
        output bus_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: turns one decoded memory request into one or two word transfers,
// lane-shifting store data and sign/zero-extending load data for writeback.
module mem_access_unit (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic              mem_wr,
    input  logic [2:0]        mem_size,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    mem_access_unit_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        RSP0,
        REQ1,
        RSP1
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic        wr_q, wr_d;
    logic [2:0]  size_q, size_d;
    logic        split_q, split_d;
    logic [29:0] waddr1_q, waddr1_d;
    logic [3:0]  be1_q, be1_d;
    logic [31:0] whi_q, whi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [29:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    logic [3:0]  size_mask;
    logic [7:0]  lane_span;
    logic [63:0] w_shift;
    logic        req_legal;

    // Select the accessed bytes from the {hi, lo} word pair starting at the byte offset.
    function automatic logic [31:0] format_load(input logic [63:0] pair,
                                                input logic [1:0]  off,
                                                input logic [2:0]  size);
        logic [31:0] d;
        d = pair[{off, 3'b000} +: 32];
        case (size)
            3'b000:  format_load = {{24{d[7]}}, d[7:0]};
            3'b001:  format_load = {{16{d[15]}}, d[15:0]};
            3'b100:  format_load = {24'h0, d[7:0]};
            3'b101:  format_load = {16'h0, d[15:0]};
            default: format_load = d;
        endcase
    endfunction

    // Lanes spilling past bit 3 of lane_span belong to the following word.
    always_comb begin
        case (mem_size[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        lane_span = {4'b0000, size_mask} << addr[1:0];
        w_shift   = {32'h0, wdata} << {addr[1:0], 3'b000};
        case (mem_size)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = ~mem_wr;
            default:                req_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        wr_d        = wr_q;
        size_d      = size_q;
        split_d     = split_q;
        waddr1_d    = waddr1_q;
        be1_d       = be1_q;
        whi_d       = whi_q;
        lo_d        = lo_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;

        case (state_q)
            IDLE: begin
                if (mem_en) begin
                    if (!req_legal) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d     = REQ0;
                        off_d       = addr[1:0];
                        wr_d        = mem_wr;
                        size_d      = mem_size;
                        split_d     = |lane_span[7:4];
                        waddr1_d    = addr[31:2] + 30'd1;
                        be1_d       = lane_span[7:4];
                        whi_d       = w_shift[63:32];
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_wr;
                        bus_addr_d  = addr[31:2];
                        bus_be_d    = lane_span[3:0];
                        bus_wdata_d = w_shift[31:0];
                    end
                end
            end

            REQ0: begin
                if (bus.bus_gnt) begin
                    if (!wr_q) begin
                        bus_req_d = 1'b0;
                        state_d   = RSP0;
                    end else if (split_q) begin
                        // Second store word issues back-to-back without dropping bus_req.
                        state_d     = REQ1;
                        bus_addr_d  = waddr1_q;
                        bus_be_d    = be1_q;
                        bus_wdata_d = whi_q;
                    end else begin
                        bus_req_d = 1'b0;
                        state_d   = IDLE;
                        done_d    = 1'b1;
                    end
                end
            end

            RSP0: begin
                if (bus.bus_rvalid) begin
                    lo_d = bus.bus_rdata;
                    if (split_q) begin
                        state_d     = REQ1;
                        bus_req_d   = 1'b1;
                        bus_addr_d  = waddr1_q;
                        bus_be_d    = be1_q;
                        bus_wdata_d = whi_q;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        rdata_d = format_load({32'h0, bus.bus_rdata}, off_q, size_q);
                    end
                end
            end

            REQ1: begin
                if (bus.bus_gnt) begin
                    bus_req_d = 1'b0;
                    if (wr_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RSP1;
                    end
                end
            end

            RSP1: begin
                if (bus.bus_rvalid) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    rdata_d = format_load({bus.bus_rdata, lo_q}, off_q, size_q);
                end
            end

            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            off_q       <= '0;
            wr_q        <= 1'b0;
            size_q      <= '0;
            split_q     <= 1'b0;
            waddr1_q    <= '0;
            be1_q       <= '0;
            whi_q       <= '0;
            lo_q        <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            wr_q        <= wr_d;
            size_q      <= size_d;
            split_q     <= split_d;
            waddr1_q    <= waddr1_d;
            be1_q       <= be1_d;
            whi_q       <= whi_d;
            lo_q        <= lo_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign rdata         = rdata_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign err           = err_q;
    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-level reference memory predicts transfers,
// load results and latencies; a randomly stalling bus slave model backs the DUT.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_en = 1'b0;
    logic        mem_wr = 1'b0;
    logic [2:0]  mem_size = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;

    mem_access_unit_if bus_if();

    mem_access_unit dut (
        .clk      (clk),
        .rst      (rst),
        .mem_en   (mem_en),
        .mem_wr   (mem_wr),
        .mem_size (mem_size),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc;
        int          lat;
    } resp_t;

    typedef struct {
        logic        we;
        logic [29:0] waddr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } xfer_t;

    resp_t resp_q[$];
    xfer_t xfer_q[$];
    logic [31:0] last_rdata = '0;

    logic [31:0] bus_mem [logic [29:0]];
    logic [7:0]  ref_mem [logic [31:0]];

    // slave model controls; the mux lets a directed test take the bus by hand
    int          gw_min = 0, gw_max = 0, rv_min = 0, rv_max = 0;
    bit          noise_en = 0;
    bit          slave_hold = 0;
    logic        sl_gnt = 0, sl_rvalid = 0, man_gnt = 0, man_rvalid = 0;
    logic [31:0] sl_rdata = '0, man_rdata = '0;

    assign bus_if.bus_gnt    = slave_hold ? man_gnt    : sl_gnt;
    assign bus_if.bus_rvalid = slave_hold ? man_rvalid : sl_rvalid;
    assign bus_if.bus_rdata  = slave_hold ? man_rdata  : sl_rdata;

    function automatic logic [31:0] init_word(input logic [29:0] w);
        return ({w, 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [29:0] w);
        return bus_mem.exists(w) ? bus_mem[w] : init_word(w);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] w;
        if (ref_mem.exists(a)) return ref_mem[a];
        w = init_word(a[31:2]);
        return w[8*a[1:0] +: 8];
    endfunction

    task automatic preload(input logic [29:0] w, input logic [31:0] v);
        logic [1:0] lane;
        bus_mem[w] = v;
        for (int i = 0; i < 4; i++) begin
            lane = 2'(i);
            ref_mem[{w, lane}] = v[8*i +: 8];
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    // Byte-level reference: each accessed byte lands in the word holding its own address.
    task automatic model_req(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                             input logic [31:0] d, output resp_t r);
        int          n;
        int          k;
        bit          legal;
        bit          used1;
        logic [31:0] ba;
        logic [31:0] val;
        xfer_t       x[2];
        legal = wr ? (sz inside {3'b000, 3'b001, 3'b010})
                   : (sz inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        n = (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
        r.err = !legal;
        r.acc = 0;
        r.lat = 0;
        if (legal) begin
            used1 = 0;
            val   = '0;
            for (int j = 0; j < 2; j++) x[j] = '{we: wr, waddr: '0, be: '0, wdata: '0};
            for (int i = 0; i < n; i++) begin
                ba = a + 32'(i);
                k  = (ba[31:2] == a[31:2]) ? 0 : 1;
                if (k == 1) used1 = 1;
                x[k].waddr = ba[31:2];
                x[k].be[ba[1:0]] = 1'b1;
                if (wr) begin
                    x[k].wdata[8*ba[1:0] +: 8] = d[8*i +: 8];
                    ref_mem[ba] = d[8*i +: 8];
                end else begin
                    val[8*i +: 8] = ref_byte(ba);
                end
            end
            if (!wr) begin
                if (!sz[2] && n == 1) val = {{24{val[7]}}, val[7:0]};
                if (!sz[2] && n == 2) val = {{16{val[15]}}, val[15:0]};
                last_rdata = val;
            end
            xfer_q.push_back(x[0]);
            if (used1) xfer_q.push_back(x[1]);
        end
        r.rdata = last_rdata;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the accept edge.
    task automatic issue(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input int lat);
        int    guard;
        resp_t r;
        guard = 0;
        while (busy && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (busy) begin
            fail("issue_timeout", "DUT stayed busy");
            return;
        end
        model_req(wr, sz, a, d, r);
        mem_en = 1'b1; mem_wr = wr; mem_size = sz; addr = a; wdata = d;
        @(posedge clk); #1;
        mem_en = 1'b0; mem_wr = 1'($urandom); mem_size = 3'($urandom);
        addr = $urandom; wdata = $urandom;
        r.acc = cyc;
        r.lat = lat;
        resp_q.push_back(r);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((busy || resp_q.size() != 0) && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (busy || resp_q.size() != 0) fail("idle_timeout", "access never completed");
    endtask

    // bus slave: random grant stalls, random read latency, stray rvalid while no read pending
    initial begin
        bit          acc, rd_pend, req_seen;
        logic        acc_we;
        logic [29:0] acc_a, rd_a;
        logic [3:0]  acc_be;
        logic [31:0] acc_d, cur;
        int          rd_cnt, gwait;
        rd_pend = 0; req_seen = 0; rd_cnt = 0; gwait = 0; rd_a = '0;
        forever begin
            @(negedge clk);
            acc    = bus_if.bus_req && bus_if.bus_gnt;
            acc_we = bus_if.bus_we;
            acc_a  = bus_if.bus_addr;
            acc_be = bus_if.bus_be;
            acc_d  = bus_if.bus_wdata;
            @(posedge clk);
            if (slave_hold || !rst) begin
                rd_pend = 0; req_seen = 0; sl_gnt = 0; sl_rvalid = 0;
                continue;
            end
            if (acc) begin
                if (acc_we) begin
                    cur = mem_rd(acc_a);
                    for (int i = 0; i < 4; i++)
                        if (acc_be[i]) cur[8*i +: 8] = acc_d[8*i +: 8];
                    bus_mem[acc_a] = cur;
                end else begin
                    rd_pend = 1;
                    rd_a    = acc_a;
                    rd_cnt  = $urandom_range(rv_max, rv_min);
                end
            end
            #1;
            sl_gnt = 0;
            sl_rvalid = 0;
            if (rd_pend) begin
                if (rd_cnt == 0) begin
                    sl_rvalid = 1; sl_rdata = mem_rd(rd_a); rd_pend = 0;
                end else begin
                    rd_cnt--;
                end
            end else if (noise_en && $urandom_range(0, 7) == 0) begin
                sl_rvalid = 1; sl_rdata = $urandom;
            end
            if (bus_if.bus_req) begin
                if (!req_seen) begin
                    req_seen = 1;
                    gwait = $urandom_range(gw_max, gw_min);
                end
                if (gwait == 0) begin
                    sl_gnt = 1; req_seen = 0;
                end else begin
                    gwait--;
                end
            end else begin
                req_seen = 0;
            end
        end
    end

    // monitor: transfers, stall stability, completions
    initial begin
        bit          pv_stall;
        logic [34:0] pv_ctl;
        logic [31:0] pv_wd;
        xfer_t       x;
        resp_t       r;
        logic [31:0] m;
        pv_stall = 0; pv_ctl = '0; pv_wd = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pv_stall = 0;
                continue;
            end
            if (pv_stall) begin
                chk("stall_req", bus_if.bus_req, 1);
                chk("stall_ctl", {bus_if.bus_we, bus_if.bus_be, bus_if.bus_addr}, pv_ctl);
                chk("stall_wdata", bus_if.bus_wdata, pv_wd);
            end
            pv_stall = bus_if.bus_req && !bus_if.bus_gnt;
            pv_ctl   = {bus_if.bus_we, bus_if.bus_be, bus_if.bus_addr};
            pv_wd    = bus_if.bus_wdata;
            chk("req_while_idle", bus_if.bus_req & ~busy, 0);
            chk("err_without_done", err & ~done, 0);
            if (bus_if.bus_req && bus_if.bus_gnt) begin
                if (xfer_q.size() == 0) begin
                    fail("xfer_unexpected", $sformatf("addr 0x%0h", bus_if.bus_addr));
                end else begin
                    x = xfer_q.pop_front();
                    chk("xfer_we", bus_if.bus_we, x.we);
                    chk("xfer_addr", bus_if.bus_addr, x.waddr);
                    chk("xfer_be", bus_if.bus_be, x.be);
                    chk("xfer_wdata_known", $isunknown(bus_if.bus_wdata), 0);
                    if (x.we) begin
                        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{x.be[i]}};
                        chk("xfer_wdata", bus_if.bus_wdata & m, x.wdata & m);
                    end
                end
            end
            if (done) begin
                if (resp_q.size() == 0) begin
                    fail("done_unexpected", "no access outstanding");
                end else begin
                    r = resp_q.pop_front();
                    chk("resp_err", err, r.err);
                    chk("resp_rdata", rdata, r.rdata);
                    if (r.lat > 0) chk("resp_latency", cyc - r.acc + 1, r.lat);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_bus", {bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_be}, 0);
        chk("rst_bus_wdata", bus_if.bus_wdata, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        preload(30'h40, 32'hDEAD_BEEF);
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0, 3);
        wait_idle();
        chk("lw_aligned", rdata, 32'hDEAD_BEEF);

        preload(30'h40, 32'h80FF_FF7F);
        issue(1'b0, 3'b000, 32'h0000_0103, 32'h0, 3);
        wait_idle();
        chk("lb_sign", rdata, 32'hFFFF_FF80);
        issue(1'b0, 3'b100, 32'h0000_0103, 32'h0, 3);
        wait_idle();
        chk("lbu_zero", rdata, 32'h0000_0080);

        issue(1'b1, 3'b001, 32'h0000_0203, 32'h0000_ABCD, 3);
        issue(1'b0, 3'b001, 32'h0000_0203, 32'h0, 5);
        wait_idle();
        chk("sh_split_readback", rdata, 32'hFFFF_ABCD);

        preload(30'h3FFF_FFFF, 32'h1122_3344);
        preload(30'h0, 32'h5566_7788);
        issue(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 5);
        wait_idle();
        chk("lw_wrap", rdata, 32'h7788_1122);

        gw_min = 4; gw_max = 4;
        issue(1'b1, 3'b010, 32'h0000_0300, 32'h1357_9BDF, 6);
        wait_idle();
        gw_min = 0; gw_max = 0;

        issue(1'b0, 3'b011, 32'h0000_0100, 32'h0, 1);
        issue(1'b1, 3'b100, 32'h0000_0104, 32'hFFFF_FFFF, 1);
        wait_idle();
        chk("illegal_rdata_kept", rdata, 32'h7788_1122);

        // reset abandons a load waiting in RSP0; a late rvalid must not land
        slave_hold = 1;
        preload(30'h50, 32'hCAFE_F00D);
        xfer_q.push_back('{we: 1'b0, waddr: 30'h50, be: 4'hF, wdata: 32'h0});
        mem_en = 1'b1; mem_wr = 1'b0; mem_size = 3'b010; addr = 32'h0000_0140;
        @(posedge clk); #1;
        mem_en = 1'b0;
        man_gnt = 1'b1;
        @(posedge clk); #1;
        man_gnt = 1'b0;
        chk("rsp0_busy", busy, 1);
        chk("rsp0_req", bus_if.bus_req, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_req", bus_if.bus_req, 0);
        chk("midrst_rdata", rdata, 0);
        last_rdata = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        man_rvalid = 1'b1; man_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        man_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("late_rvalid_rdata", rdata, 0);
        chk("late_rvalid_busy", busy, 0);
        slave_hold = 0;

        gw_min = 0; gw_max = 3; rv_min = 0; rv_max = 3; noise_en = 1;
        for (int t = 0; t < 400; t++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'h0000_0100 + $urandom_range(0, 31);
                1:       a = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                2:       a = $urandom;
                default: a = $urandom_range(0, 15);
            endcase
            issue(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        chk("resp_queue_drained", resp_q.size(), 0);
        chk("xfer_queue_drained", xfer_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
